// File: rtl/pe_mode0_seq.sv
// Sequencer for one PE mode-0 pass: configure the PE, stream weights, stream a
// full fmap column followed by cfg_nslide shifted columns (one MAC pass per
// column), then drain the partial sums.
module pe_mode0_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PARA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [PARA_WIDTH-1:0] cfg_S,
    input  logic [PARA_WIDTH-1:0] cfg_U,
    input  logic [PARA_WIDTH-1:0] cfg_q,
    input  logic [PARA_WIDTH-1:0] cfg_p,
    input  logic [PARA_WIDTH-1:0] cfg_nslide,
    input  logic [DATA_WIDTH-1:0] w_src_data,
    input  logic                  w_src_valid,
    output logic                  w_src_ready,
    input  logic [DATA_WIDTH-1:0] f_src_data,
    input  logic                  f_src_valid,
    output logic                  f_src_ready,
    input  logic                  fifo_full_filter,
    input  logic                  fifo_full_fmap,
    input  logic                  mac_finish,
    input  logic                  psum_out_valid,
    output logic                  start_config,
    output logic                  start_weight_load,
    output logic                  start_feature_load,
    output logic                  psum_out_start,
    output logic                  load_full_cloumn,
    output logic [DATA_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0] feature_in,
    output logic                  weight_in_en,
    output logic                  feature_in_en,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic [3:0] {
        StIdle, StCfg, StWStart, StWStream, StFStart,
        StFStream, StWaitMac, StPStart, StPDrain, StDone
    } state_e;

    state_e state_q, state_d;

    logic [PARA_WIDTH-1:0] s_q, u_q, q_q, p_q, nslide_q;
    logic [PARA_WIDTH-1:0] slide_cnt_q, p_cnt_q;
    logic [CNT_WIDTH-1:0]  w_cnt_q, f_cnt_q;
    logic                  load_full_q, cfg_err_q;

    logic [CNT_WIDTH-1:0]  nw, nf_full, nf_shift, f_target;
    logic                  cfg_bad, w_hs, f_hs, w_last, f_last, slide_more, p_last;

    // Operands are widened before multiplying so the products never truncate.
    assign nw       = CNT_WIDTH'(s_q) * CNT_WIDTH'(q_q) * CNT_WIDTH'(p_q);
    assign nf_full  = CNT_WIDTH'(s_q) * CNT_WIDTH'(q_q);
    assign nf_shift = CNT_WIDTH'(u_q) * CNT_WIDTH'(q_q);
    assign f_target = load_full_q ? nf_full : nf_shift;

    // Checked against the live inputs, since latching happens on the same edge.
    assign cfg_bad = (cfg_S == '0) || (cfg_U == '0) || (cfg_q == '0) || (cfg_p == '0);

    assign w_hs       = (state_q == StWStream) && w_src_valid && !fifo_full_filter;
    assign f_hs       = (state_q == StFStream) && f_src_valid && !fifo_full_fmap;
    assign w_last     = (w_cnt_q == nw - CNT_WIDTH'(1));
    assign f_last     = (f_cnt_q == f_target - CNT_WIDTH'(1));
    assign slide_more = (slide_cnt_q < nslide_q);
    assign p_last     = (p_cnt_q == p_q - PARA_WIDTH'(1));

    assign weight_in  = w_src_data;
    assign feature_in = f_src_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (go && !cfg_bad) state_d = StCfg;
            StCfg:     state_d = StWStart;
            StWStart:  state_d = StWStream;
            StWStream: if (w_hs && w_last) state_d = StFStart;
            StFStart:  state_d = StFStream;
            StFStream: if (f_hs && f_last) state_d = StWaitMac;
            StWaitMac: if (mac_finish) state_d = slide_more ? StFStart : StPStart;
            StPStart:  state_d = StPDrain;
            StPDrain:  if (psum_out_valid && p_last) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Moore pulses plus the combinational stream handshakes.
    always_comb begin
        start_config       = (state_q == StCfg);
        start_weight_load  = (state_q == StWStart);
        start_feature_load = (state_q == StFStart);
        psum_out_start     = (state_q == StPStart);
        done               = (state_q == StDone);
        busy               = (state_q != StIdle);
        w_src_ready        = (state_q == StWStream) && !fifo_full_filter;
        f_src_ready        = (state_q == StFStream) && !fifo_full_fmap;
        weight_in_en       = w_hs;
        feature_in_en      = f_hs;
        load_full_cloumn   = load_full_q;
        cfg_err            = cfg_err_q;
    end

    // Config latch and the error pulse raised on a rejected go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= '0;
            u_q       <= '0;
            q_q       <= '0;
            p_q       <= '0;
            nslide_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (state_q == StIdle && go) begin
                s_q       <= cfg_S;
                u_q       <= cfg_U;
                q_q       <= cfg_q;
                p_q       <= cfg_p;
                nslide_q  <= cfg_nslide;
                cfg_err_q <= cfg_bad;
            end
        end
    end

    // Transfer, slide and psum counters plus the full-column flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt_q     <= '0;
            f_cnt_q     <= '0;
            slide_cnt_q <= '0;
            p_cnt_q     <= '0;
            load_full_q <= 1'b0;
        end else begin
            if (state_q == StCfg) begin
                w_cnt_q     <= '0;
                slide_cnt_q <= '0;
            end
            if (w_hs) begin
                w_cnt_q <= w_cnt_q + CNT_WIDTH'(1);
                if (w_last) load_full_q <= 1'b1;
            end
            if (state_q == StFStart) f_cnt_q <= '0;
            if (f_hs) f_cnt_q <= f_cnt_q + CNT_WIDTH'(1);
            if (state_q == StWaitMac && mac_finish && slide_more) begin
                slide_cnt_q <= slide_cnt_q + PARA_WIDTH'(1);
                load_full_q <= 1'b0;
            end
            if (state_q == StPStart) p_cnt_q <= '0;
            if (state_q == StPDrain && psum_out_valid) p_cnt_q <= p_cnt_q + PARA_WIDTH'(1);
            if (state_q == StDone) load_full_q <= 1'b0;
        end
    end

endmodule

// File: doc/pe_mode0_seq.md
PE_MODE0_SEQ -- requirements
Module: pe_mode0_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, width of weight/fmap words.
REQ-002 SHALL have parameter PARA_WIDTH, 8, width of each configuration field.
REQ-003 SHALL have parameter CNT_WIDTH, 24, width of transfer counters (≥ 3*PARA_WIDTH).
REQ-004 SHALL have ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- go  input  1  start pulse; sampled only in IDLE.
- cfg_S, cfg_U, cfg_q, cfg_p  input  PARA_WIDTH each  filter width, stride, channels, filters.
- cfg_nslide  input  PARA_WIDTH  number of shift loads after the full-column load.
- w_src_data  input  DATA_WIDTH  weight word from the bus.
- w_src_valid  input  1  weight word present.
- w_src_ready  output  1  weight word accepted this cycle.
- f_src_data  input  DATA_WIDTH  fmap word from the bus.
- f_src_valid  input  1  fmap word present.
- f_src_ready  output  1  fmap word accepted this cycle.
- fifo_full_filter, fifo_full_fmap  input  1 each  PE input FIFO full.
- mac_finish  input  1  PE MAC pass done (pulse).
- psum_out_valid  input  1  PE psum word valid.
- start_config, start_weight_load, start_feature_load, psum_out_start  output  1 each  one-cycle PE control pulses.
- load_full_cloumn  output  1  level; 1 during full-column fmap load.
- weight_in, feature_in  output  DATA_WIDTH  pass-through of w_src_data / f_src_data.
- weight_in_en, feature_in_en  output  1  PE write enables.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse at sequence completion.
- cfg_err  output  1  one-cycle pulse on rejected go.

Function
REQ-005 SHALL implement states IDLE, CFG, W_START, W_STREAM, F_START, F_STREAM, WAIT_MAC, P_START, P_DRAIN, DONE.
REQ-006 SHALL, in IDLE on go=1, latch all cfg_* inputs; if cfg_S, cfg_q, cfg_p or cfg_U is 0, pulse cfg_err next cycle and remain IDLE; else go to CFG.
REQ-007 SHALL compute NW=S*q*p, NF_FULL=S*q, NF_SHIFT=U*q in CNT_WIDTH unsigned arithmetic from latched values, without truncation.
REQ-008 SHALL assert start_config for exactly the one cycle spent in CFG, then enter W_START.
REQ-009 SHALL assert start_weight_load for the one cycle in W_START, then enter W_STREAM.
REQ-010 SHALL in W_STREAM drive w_src_ready = !fifo_full_filter and weight_in_en = w_src_valid & w_src_ready, combinationally; each handshake counts one weight.
REQ-011 SHALL leave W_STREAM the cycle after the NW-th handshake, entering F_START with load_full_cloumn=1.
REQ-012 SHALL assert start_feature_load for the one cycle in F_START, then enter F_STREAM.
REQ-013 SHALL in F_STREAM drive f_src_ready = !fifo_full_fmap and feature_in_en = f_src_valid & f_src_ready; target count NF_FULL when load_full_cloumn=1, else NF_SHIFT.
REQ-014 SHALL enter WAIT_MAC after the final fmap handshake and hold there until mac_finish=1.
REQ-015 SHALL, on mac_finish, with slides issued < cfg_nslide: increment slide counter, clear load_full_cloumn, go to F_START; otherwise go to P_START.
REQ-016 SHALL ignore mac_finish in every state other than WAIT_MAC.
REQ-017 SHALL assert psum_out_start for the one cycle in P_START, then in P_DRAIN count psum_out_valid cycles and leave after the p-th.
REQ-018 SHALL pulse done for the one cycle in DONE, then return to IDLE.
REQ-019 SHALL keep w_src_ready, f_src_ready, weight_in_en, feature_in_en at 0 outside their stream states.
REQ-020 SHALL ignore go while busy=1.
REQ-021 SHALL, when a FIFO-full input is high, stall the stream without losing or double-counting words.

Reset
REQ-022 SHALL, on rst=1 at any time, enter IDLE immediately and clear all counters and latched config.
REQ-023 SHALL reset all outputs to 0 (weight_in/feature_in are pass-through and are not reset).
REQ-024 SHALL, after mid-sequence reset, require a new go; no residual pulses.

Verification
REQ-025 SHALL cover nominal: S=3,U=1,q=4,p=3,nslide=2, always-valid sources -> 36 weight_in_en, 12 feature_in_en with load_full_cloumn=1, then 2×4 with it 0, 3 mac_finish waits, psum_out_start once, done after 3 psum_out_valid.
REQ-026 SHALL cover backpressure: fifo_full_filter toggling every other cycle -> still exactly 36 weights, in order 1..36.
REQ-027 SHALL cover bad config: go with q=0 -> cfg_err pulse one cycle later, busy stays 0, no start_config.
REQ-028 SHALL cover reset mid W_STREAM after 10 weights -> all outputs 0 next cycle, IDLE; a new go restarts at weight count 0.
REQ-029 SHALL cover stray events: mac_finish during W_STREAM and go during F_STREAM -> both ignored, sequence unchanged.
